// File: rtl/voting_pkg.sv
// voting_pkg: shared FSM state type, default sizing and ballot helper
// for the voting session controller and its arbiter.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DONE
  } state_e;

  localparam int NUM_VOTERS_DEF = 4;
  localparam int NUM_CAND_DEF   = 3;
  localparam int CNT_W_DEF      = 8;

  // true when exactly one bit is set
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requesters.
// Search starts at the requester after the last accepted grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;

  // scan from the pointer downward in priority so the closest wins
  always_comb begin
    o_grant = '0;
    w_gidx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      logic [PW-1:0] k;
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      k = PW'(j);
      if (i_req[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        w_gidx     = k;
      end
    end
  end

  // move past the granted requester only when it was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      if (int'(w_gidx) == N - 1) r_ptr <= '0;
      else r_ptr <= w_gidx + 1'b1;
    end
  end

endmodule

// File: rtl/voting_session_ctrl.sv
// voting_session_ctrl: ballot collection, saturating tallies, winner scan.
// VOTING_SESSION_COUNTS_EN exposes live tallies and a sticky sat_flag.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int NUM_VOTERS = NUM_VOTERS_DEF,
  parameter int NUM_CAND   = NUM_CAND_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           close,
  input  logic [NUM_VOTERS-1:0]          ballot_valid,
  input  logic [NUM_VOTERS*NUM_CAND-1:0] ballot_cand,
  output logic [NUM_VOTERS-1:0]          ballot_ready,
  output logic                           busy,
  output logic                           result_valid,
  output logic [NUM_CAND-1:0]            winner,
  output logic                           tie,
  output logic                           no_votes
`ifdef VOTING_SESSION_COUNTS_EN
  ,
  output logic [NUM_CAND*CNT_W-1:0]      tally_out,
  output logic                           sat_flag
`endif
);

  localparam int CW = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] MAXC = '1;

  state_e r_state;
  state_e w_next;

  logic [CNT_W-1:0]      r_tally [NUM_CAND];
  logic [NUM_VOTERS-1:0] r_voted;
  logic [NUM_VOTERS-1:0] w_req;
  logic [NUM_VOTERS-1:0] w_grant;
  logic [NUM_CAND-1:0]   w_sel;
  logic                  w_hs;
  logic                  w_count;
  logic                  w_open;
  logic                  w_last;
  logic [CNT_W-1:0]      w_cur;
  logic [CNT_W-1:0]      r_max;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         r_best;
  logic                  r_tie;

  assign w_open = start && (r_state == IDLE || r_state == DONE);
  assign w_req  = (r_state == COLLECT) ? ballot_valid : '0;

  rr_arbiter #(.N(NUM_VOTERS)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_accept (w_hs),
    .o_grant  (w_grant)
  );

  assign ballot_ready = w_grant;
  assign w_hs         = |w_grant;

  // pick the ballot of the granted voter
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_VOTERS; i++)
      if (w_grant[i]) w_sel = ballot_cand[i*NUM_CAND +: NUM_CAND];
  end

  assign w_count = w_hs && ((w_grant & r_voted) == '0)
                   && is_onehot(32'(w_sel));
  assign w_cur   = r_tally[r_idx];
  assign w_last  = (r_idx == CW'(NUM_CAND - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = COLLECT;
      COLLECT: if (close || (&r_voted)) w_next = DECIDE;
      DECIDE:  if (w_last) w_next = DONE;
      DONE:    if (start) w_next = COLLECT;
      default: w_next = IDLE;
    endcase
  end

  // tallies and voted mask; any handshake burns the voter's vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_voted <= '0;
      for (int c = 0; c < NUM_CAND; c++) r_tally[c] <= '0;
    end else if (w_open) begin
      r_voted <= '0;
      for (int c = 0; c < NUM_CAND; c++) r_tally[c] <= '0;
    end else if (w_hs) begin
      r_voted <= r_voted | w_grant;
      if (w_count)
        for (int c = 0; c < NUM_CAND; c++)
          if (w_sel[c] && r_tally[c] != MAXC)
            r_tally[c] <= r_tally[c] + 1'b1;
    end
  end

  // one candidate per cycle; a later equal tally never displaces the best
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_best <= '0;
      r_max  <= '0;
      r_tie  <= 1'b0;
    end else if (r_state == COLLECT) begin
      r_idx  <= '0;
      r_best <= '0;
      r_max  <= '0;
      r_tie  <= 1'b0;
    end else if (r_state == DECIDE) begin
      if (!w_last) r_idx <= r_idx + 1'b1;
      if (w_cur > r_max) begin
        r_max  <= w_cur;
        r_best <= r_idx;
        r_tie  <= 1'b0;
      end else if (w_cur == r_max && w_cur != '0) begin
        r_tie <= 1'b1;
      end
    end
  end

  assign busy         = (r_state == COLLECT) || (r_state == DECIDE);
  assign result_valid = (r_state == DONE);
  assign no_votes     = result_valid && (r_max == '0);
  assign tie          = result_valid && r_tie;
  assign winner       = (result_valid && r_max != '0)
                        ? ({{(NUM_CAND-1){1'b0}}, 1'b1} << r_best)
                        : '0;

`ifdef VOTING_SESSION_COUNTS_EN
  logic r_sat;
  logic w_any_max;

  // flag any tally sitting at its ceiling
  always_comb begin
    w_any_max = 1'b0;
    for (int c = 0; c < NUM_CAND; c++)
      if (r_tally[c] == MAXC) w_any_max = 1'b1;
  end

  // sticky per session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sat <= 1'b0;
    else if (w_open) r_sat <= 1'b0;
    else if (w_any_max) r_sat <= 1'b1;
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tal
    assign tally_out[g*CNT_W +: CNT_W] = r_tally[g];
  end
  assign sat_flag = r_sat;
`endif

endmodule
